// File: rtl/riscv_decode_pkg.sv
// Shared decode constants and the ID/EX pipeline register payload.
package riscv_decode_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_LT  = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SLL = 4'b1001,
    ALU_SRA = 4'b1010,
    ALU_XOR = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic              valid;
    alu_op_e           alu_op;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              illegal;
  } id_ex_t;

  // Empty pipeline slot: everything zero except a harmless ADD opcode.
  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b        = '0;
    b.alu_op = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder producing the ID/EX payload and an illegal flag.
module instr_decoder
  import riscv_decode_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output id_ex_t          dec,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};

  // Opcode/funct3 decode; fields not used by an instruction class stay zero.
  always_comb begin
    dec         = id_ex_bubble();
    dec.valid   = 1'b1;
    illegal     = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        dec.op1       = rs1_data;
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
        if (opcode == OP_R) begin
          dec.op2      = rs2_data;
          dec.rs2      = instr[24:20];
          dec.rs2_data = rs2_data;
        end else begin
          dec.op2 = imm_i;
          dec.imm = imm_i;
        end
        case (funct3)
          F3_ADD:  dec.alu_op = (opcode == OP_R && instr[30]) ? ALU_SUB : ALU_ADD;
          F3_SLL:  dec.alu_op = ALU_SLL;
          F3_SLT:  dec.alu_op = ALU_LT;
          F3_SLTU: illegal    = 1'b1;
          F3_XOR:  dec.alu_op = ALU_XOR;
          F3_SR:   dec.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
          F3_OR:   dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        dec.op1       = rs1_data;
        dec.op2       = imm_i;
        dec.imm       = imm_i;
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        dec.op1       = rs1_data;
        dec.op2       = imm_s;
        dec.imm       = imm_s;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rs2_data  = rs2_data;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.op1      = rs1_data;
        dec.op2      = rs2_data;
        dec.imm      = imm_b;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rs2_data = rs2_data;
        dec.alu_op   = ALU_SUB;
        dec.branch   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.op1       = (opcode == OP_AUIPC) ? pc : '0;
        dec.op2       = imm_u;
        dec.imm       = imm_u;
        dec.rd        = instr[11:7];
        dec.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// ID/EX pipeline register with stall, flush and illegal-instruction squash.
// Optional macro ID_EX_ILLEGAL_COUNT_EN adds a saturating illegal_count port.
module id_ex_decode
  import riscv_decode_pkg::*;
#(
  parameter int unsigned ID_EX_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [31:0]            id_instr,
  input  logic [ID_EX_WIDTH-1:0] id_pc,
  input  logic [ID_EX_WIDTH-1:0] id_rs1_data,
  input  logic [ID_EX_WIDTH-1:0] id_rs2_data,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   ex_valid,
  output logic [3:0]             ex_alu_op,
  output logic [ID_EX_WIDTH-1:0] ex_op1,
  output logic [ID_EX_WIDTH-1:0] ex_op2,
  output logic [ID_EX_WIDTH-1:0] ex_rs2_data,
  output logic [ID_EX_WIDTH-1:0] ex_imm,
  output logic [4:0]             ex_rd,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_branch,
  output logic                   ex_illegal
`ifdef ID_EX_ILLEGAL_COUNT_EN
  ,
  output logic [15:0]            illegal_count
`endif
);

  id_ex_t dec;
  logic   dec_illegal;
  id_ex_t id_ex_q;
  id_ex_t id_ex_d;

  instr_decoder u_instr_decoder (
    .instr    (id_instr),
    .pc       (id_pc),
    .rs1_data (id_rs1_data),
    .rs2_data (id_rs2_data),
    .dec      (dec),
    .illegal  (dec_illegal)
  );

  // Priority: flush > stall > legal load > illegal squash > idle bubble.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = id_ex_bubble();
    end else if (stall) begin
      id_ex_d = id_ex_q;
    end else if (id_valid && !dec_illegal) begin
      id_ex_d         = dec;
      id_ex_d.valid   = 1'b1;
      id_ex_d.illegal = 1'b0;
    end else if (id_valid) begin
      id_ex_d         = id_ex_bubble();
      id_ex_d.illegal = 1'b1;
    end else begin
      id_ex_d = id_ex_bubble();
    end
  end

  // Pipeline register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= id_ex_bubble();
    else     id_ex_q <= id_ex_d;
  end

`ifdef ID_EX_ILLEGAL_COUNT_EN
  logic [15:0] illegal_cnt_q;
  logic [15:0] illegal_cnt_d;

  // Count squashes, saturating at all-ones; flush and stall leave it alone.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (!flush && !stall && id_valid && dec_illegal && illegal_cnt_q != 16'hFFFF)
      illegal_cnt_d = illegal_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) illegal_cnt_q <= '0;
    else     illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_count = illegal_cnt_q;
`endif

  assign ex_valid     = id_ex_q.valid;
  assign ex_alu_op    = id_ex_q.alu_op;
  assign ex_op1       = id_ex_q.op1;
  assign ex_op2       = id_ex_q.op2;
  assign ex_rs2_data  = id_ex_q.rs2_data;
  assign ex_imm       = id_ex_q.imm;
  assign ex_rd        = id_ex_q.rd;
  assign ex_rs1       = id_ex_q.rs1;
  assign ex_rs2       = id_ex_q.rs2;
  assign ex_reg_write = id_ex_q.reg_write;
  assign ex_mem_read  = id_ex_q.mem_read;
  assign ex_mem_write = id_ex_q.mem_write;
  assign ex_branch    = id_ex_q.branch;
  assign ex_illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for id_ex_decode; inputs driven and outputs sampled on negedge.
module tb_id_ex_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;
`ifdef ID_EX_ILLEGAL_COUNT_EN
  logic [15:0] illegal_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_decode #(.ID_EX_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_alu_op    (ex_alu_op),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_rs2_data  (ex_rs2_data),
    .ex_imm       (ex_imm),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_branch    (ex_branch),
    .ex_illegal   (ex_illegal)
`ifdef ID_EX_ILLEGAL_COUNT_EN
    ,
    .illegal_count(illegal_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    id_valid    = 1'b1;
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = r1;
    id_rs2_data = r2;
    step();
    id_valid    = 1'b0;
  endtask

  task automatic check_bubble(input string tag, input logic exp_illegal);
    check({tag, ".valid"},  32'(ex_valid), 32'd0);
    check({tag, ".alu_op"}, 32'(ex_alu_op), 32'h2);
    check({tag, ".op1"},    ex_op1, 32'd0);
    check({tag, ".op2"},    ex_op2, 32'd0);
    check({tag, ".imm"},    ex_imm, 32'd0);
    check({tag, ".rd"},     32'(ex_rd), 32'd0);
    check({tag, ".ctrl"},   32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 32'd0);
    check({tag, ".illegal"}, 32'(ex_illegal), 32'(exp_illegal));
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; id_pc = '0;
    id_rs1_data = '0; id_rs2_data = '0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check_bubble("reset", 1'b0);
    step();
    check_bubble("idle", 1'b0);

    // sub x8,x6,x10
    issue(32'h40A30433, 32'h0, 32'd7, 32'd3);
    check("sub.alu_op", 32'(ex_alu_op), 32'h6);
    check("sub.op1", ex_op1, 32'd7);
    check("sub.op2", ex_op2, 32'd3);
    check("sub.rd", 32'(ex_rd), 32'd8);
    check("sub.rs1", 32'(ex_rs1), 32'd6);
    check("sub.rs2", 32'(ex_rs2), 32'd10);
    check("sub.reg_write", 32'(ex_reg_write), 32'd1);
    check("sub.valid", 32'(ex_valid), 32'd1);

    // lw x1,-4(x2)
    issue(32'hFFC12083, 32'h0, 32'h100, 32'h0);
    check("lw.alu_op", 32'(ex_alu_op), 32'h2);
    check("lw.op1", ex_op1, 32'h100);
    check("lw.op2", ex_op2, 32'hFFFFFFFC);
    check("lw.imm", ex_imm, 32'hFFFFFFFC);
    check("lw.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 32'b1100);
    check("lw.rd", 32'(ex_rd), 32'd1);
    check("lw.rs1", 32'(ex_rs1), 32'd2);

    // srai x5,x6,31
    issue(32'h41F35293, 32'h0, 32'h80000000, 32'h0);
    check("srai.alu_op", 32'(ex_alu_op), 32'hA);
    check("srai.op1", ex_op1, 32'h80000000);
    check("srai.op2", ex_op2, 32'h41F);
    check("srai.rd", 32'(ex_rd), 32'd5);

    // sltu: squashed with a one-cycle illegal pulse
    issue(32'h0000B033, 32'h0, 32'h1, 32'h2);
    check_bubble("sltu", 1'b1);
`ifdef ID_EX_ILLEGAL_COUNT_EN
    check("sltu.count", 32'(illegal_count), 32'd1);
`endif
    step();
    check("sltu.pulse_end", 32'(ex_illegal), 32'd0);

    // Unknown opcode squashed, then a stall holds the pulse
    issue(32'h0000007F, 32'h0, 32'h0, 32'h0);
    check("badop.illegal", 32'(ex_illegal), 32'd1);
    stall = 1'b1;
    step();
    check("badop.stall_hold", 32'(ex_illegal), 32'd1);
    stall = 1'b0;
    step();
    check("badop.released", 32'(ex_illegal), 32'd0);
`ifdef ID_EX_ILLEGAL_COUNT_EN
    check("badop.count", 32'(illegal_count), 32'd2);
`endif

    // sw x2,-4(x1)
    issue(32'hFE20AE23, 32'h0, 32'h200, 32'hCAFEF00D);
    check("sw.op1", ex_op1, 32'h200);
    check("sw.op2", ex_op2, 32'hFFFFFFFC);
    check("sw.rs2_data", ex_rs2_data, 32'hCAFEF00D);
    check("sw.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 32'b0010);

    // beq x1,x2,-8
    issue(32'hFE208CE3, 32'h0, 32'd9, 32'd9);
    check("beq.alu_op", 32'(ex_alu_op), 32'h6);
    check("beq.imm", ex_imm, 32'hFFFFFFF8);
    check("beq.ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}), 32'b0001);
    check("beq.rs2", 32'(ex_rs2), 32'd2);

    // add x3,x1,x2 then 3 stalled cycles with changing inputs
    issue(32'h002081B3, 32'h0, 32'd5, 32'd6);
    check("add.op1", ex_op1, 32'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'b1;
      id_instr = 32'h40A30433 + 32'(i);
      id_rs1_data = 32'(100 + i);
      id_rs2_data = 32'(200 + i);
      step();
      check("stall.op1", ex_op1, 32'd5);
      check("stall.op2", ex_op2, 32'd6);
      check("stall.alu_op", 32'(ex_alu_op), 32'h2);
      check("stall.rd", 32'(ex_rd), 32'd3);
      check("stall.valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
    check_bubble("stall_flush", 1'b0);

    // Reset during stall clears the register
    issue(32'h002081B3, 32'h0, 32'd5, 32'd6);
    stall = 1'b1; rst = 1'b1;
    step();
    stall = 1'b0; rst = 1'b0;
    check_bubble("rst_stall", 1'b0);
`ifdef ID_EX_ILLEGAL_COUNT_EN
    check("rst.count", 32'(illegal_count), 32'd0);
`endif

    // auipc x2,0x12345 at pc 0x40
    issue(32'h12345117, 32'h40, 32'hDEAD, 32'hBEEF);
    check("auipc.op1", ex_op1, 32'h40);
    check("auipc.op2", ex_op2, 32'h12345000);
    check("auipc.alu_op", 32'(ex_alu_op), 32'h2);
    check("auipc.rd", 32'(ex_rd), 32'd2);
    check("auipc.rs1", 32'(ex_rs1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
